nonce_sweep_ctrl: RTL and testbench

//  Synthesisable sweep controller that sits between the system driver and the hash core.
//  It latches a block header, target and nonce range, then launches the hash core once
//  per nonce. Each returned hash is checked against the target. The sweep stops on the

---
 rtl/nonce_sweep_ctrl.sv | 138 +++++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: latches header/target/nonce range, launches the hash core once per nonce and checks each hash against the target; ports: start/header_in/nonce_first/nonce_last/target_in in, core_* handshake to the hash core, busy/done/found/exhausted/timeout_err/hit_*/attempts/hits status out
module nonce_sweep_ctrl #(
  parameter int HDR_BYTES   = 12,
  parameter int NONCE_BYTES = 4,
  parameter int HASH_BYTES  = 3,
  parameter int TGT_BYTES   = 1,
  parameter int STOP_ON_HIT = 1,
  parameter int TIMEOUT_CYC = 64,
  parameter int ATT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [HDR_BYTES*8-1:0] header_in,
  input  logic [NONCE_BYTES*8-1:0] nonce_first,
  input  logic [NONCE_BYTES*8-1:0] nonce_last,
  input  logic [TGT_BYTES*8-1:0] target_in,
  output logic                   core_start,
  output logic [HDR_BYTES*8-1:0] core_header,
  output logic [NONCE_BYTES*8-1:0] core_nonce,
  output logic [TGT_BYTES*8-1:0] core_target,
  input  logic                   core_done,
  input  logic [HASH_BYTES*8-1:0] core_hash,
  output logic                   busy,
  output logic                   done,
  output logic                   found,
  output logic                   exhausted,
  output logic                   timeout_err,
  output logic [NONCE_BYTES*8-1:0] hit_nonce,
  output logic [HASH_BYTES*8-1:0] hit_hash,
  output logic [ATT_W-1:0]       attempts,
  output logic [ATT_W-1:0]       hits
);
  localparam int NW = 8*NONCE_BYTES;
  localparam int HW = 8*HASH_BYTES;
  localparam int TW = 8*TGT_BYTES;
  localparam int TMW = $clog2(TIMEOUT_CYC+1);
  localparam logic SOH = STOP_ON_HIT != 0;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_CHECK, S_DONE} state_t;
  state_t state_q, state_d;
  logic [HDR_BYTES*8-1:0] header_q;
  logic [NW-1:0] nonce_q, last_q, hit_nonce_q;
  logic [TW-1:0] target_q;
  logic [HW-1:0] hash_q, hit_hash_q;
  logic [ATT_W-1:0] attempts_q, hits_q;
  logic [TMW-1:0] timer_q;
  logic found_q, exhausted_q, timeout_q, hit, tmo;
  assign hit = hash_q[HW-1 -: TW] < target_q;
  assign tmo = timer_q == TMW'(TIMEOUT_CYC-1);
  always_ff @(posedge clk)
    if (reset) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = start ? S_LOAD : S_IDLE;
      S_LOAD:   state_d = nonce_q > last_q ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   state_d = core_done ? S_CHECK : tmo ? S_DONE : S_WAIT;
      S_CHECK:  state_d = (hit && SOH) || nonce_q == last_q ? S_DONE : S_LAUNCH;
      default:  state_d = S_IDLE;
    endcase
  end
  always_comb begin
    core_start = state_q == S_LAUNCH;
    busy = state_q inside {S_LOAD, S_LAUNCH, S_WAIT, S_CHECK};
    done = state_q == S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      header_q    <= '0;
      nonce_q     <= '0;
      last_q      <= '0;
      target_q    <= '0;
      hash_q      <= '0;
      hit_nonce_q <= '0;
      hit_hash_q  <= '0;
      attempts_q  <= '0;
      hits_q      <= '0;
      timer_q     <= '0;
      found_q     <= 1'b0;
      exhausted_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          header_q    <= header_in;
          nonce_q     <= nonce_first;
          last_q      <= nonce_last;
          target_q    <= target_in;
          hit_nonce_q <= '0;
          hit_hash_q  <= '0;
          attempts_q  <= '0;
          hits_q      <= '0;
          found_q     <= 1'b0;
          exhausted_q <= 1'b0;
          timeout_q   <= 1'b0;
        end
        S_LOAD: if (nonce_q > last_q) exhausted_q <= 1'b1;
        S_LAUNCH: begin
          attempts_q <= attempts_q == '1 ? attempts_q : attempts_q + ATT_W'(1);
          timer_q    <= '0;
        end
        S_WAIT: begin
          if (core_done) hash_q <= core_hash;
          else if (tmo) timeout_q <= 1'b1;
          else timer_q <= timer_q + TMW'(1);
        end
        S_CHECK: begin
          if (hit) begin
            hits_q  <= hits_q == '1 ? hits_q : hits_q + ATT_W'(1);
            found_q <= 1'b1;
            if (!found_q) begin
              hit_nonce_q <= nonce_q;
              hit_hash_q  <= hash_q;
            end
          end
          // the last nonce never increments, so an all-ones range end cannot wrap
          if (!(hit && SOH)) begin
            if (nonce_q == last_q) exhausted_q <= 1'b1;
            else nonce_q <= nonce_q + NW'(1);
          end
        end
        default: ;
      endcase
    end
  end
  assign core_header = header_q;
  assign core_nonce  = nonce_q;
  assign core_target = target_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign timeout_err = timeout_q;
  assign hit_nonce   = hit_nonce_q;
  assign hit_hash    = hit_hash_q;
  assign attempts    = attempts_q;
  assign hits        = hits_q;
endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb_nonce_sweep_ctrl: scoreboard bench for nonce_sweep_ctrl with a reference sweep model and a hash core model
module tb_nonce_sweep_ctrl;
  localparam int TIMEOUT_CYC = 64;
  logic clk = 0, reset = 1, start = 0, core_done = 0;
  logic [95:0] header_in = '0;
  logic [31:0] nonce_first = '0, nonce_last = '0;
  logic [7:0] target_in = '0;
  logic [23:0] core_hash = '0;
  logic core_start, busy, done, found, exhausted, timeout_err;
  logic [95:0] core_header;
  logic [31:0] core_nonce, hit_nonce;
  logic [7:0] core_target;
  logic [23:0] hit_hash;
  logic [15:0] attempts, hits;
  nonce_sweep_ctrl #(.HDR_BYTES(12), .NONCE_BYTES(4), .HASH_BYTES(3), .TGT_BYTES(1),
    .STOP_ON_HIT(1), .TIMEOUT_CYC(TIMEOUT_CYC), .ATT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .header_in(header_in), .nonce_first(nonce_first),
    .nonce_last(nonce_last), .target_in(target_in), .core_start(core_start),
    .core_header(core_header), .core_nonce(core_nonce), .core_target(core_target),
    .core_done(core_done), .core_hash(core_hash), .busy(busy), .done(done), .found(found),
    .exhausted(exhausted), .timeout_err(timeout_err), .hit_nonce(hit_nonce), .hit_hash(hit_hash),
    .attempts(attempts), .hits(hits));
  always #5 clk = ~clk;
  typedef struct {
    bit found, exh, tmo;
    logic [31:0] hn;
    logic [23:0] hh;
    logic [15:0] att, hits;
    logic [95:0] hdr;
    logic [7:0] tgt;
    int kind;
    int scyc;
  } res_t;
  res_t exp_r[$];
  logic [31:0] exp_n[$];
  int n_checks = 0, n_fail = 0, cyc = 0, cs_cyc = 0;
  bit noresp = 0, hmode = 0;
  logic [31:0] special = '0;
  logic [7:0] salt = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(string nm, logic [95:0] act, logic [95:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask
  task automatic fail_now(string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask
  function automatic logic [23:0] hash_fn(logic [31:0] n);
    logic [31:0] m;
    m = n * 32'h9E3779B1;
    return hmode ? {(n == special) ? 8'h10 : 8'hFF, n[15:0]} : {m[31:24] ^ salt, m[15:0]};
  endfunction
  // hash core: answers each launch after 1..4 cycles unless told to stay silent
  initial forever begin
    @(negedge clk);
    if (core_start && !noresp) begin
      logic [31:0] n;
      n = core_nonce;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      core_hash = hash_fn(n);
      core_done = 1;
      @(negedge clk);
      core_done = 0;
      core_hash = 24'($urandom);
    end
  end
  always @(negedge clk) begin
    res_t r;
    if (core_start) begin
      cs_cyc = cyc;
      chk("busy_at_launch", busy, 1);
      if (exp_n.size() == 0) fail_now("unexpected core_start");
      else chk("core_nonce", core_nonce, exp_n.pop_front());
    end
    if (done) begin
      if (exp_r.size() == 0) fail_now("unexpected done");
      else begin
        r = exp_r.pop_front();
        chk("found", found, r.found);
        chk("exhausted", exhausted, r.exh);
        chk("timeout_err", timeout_err, r.tmo);
        chk("attempts", attempts, r.att);
        chk("hits", hits, r.hits);
        chk("hit_nonce", hit_nonce, r.hn);
        chk("hit_hash", hit_hash, r.hh);
        chk("core_header", core_header, r.hdr);
        chk("core_target", core_target, r.tgt);
        chk("busy_at_done", busy, 0);
        if (r.kind == 1) chk("empty_latency", cyc - r.scyc, 2);
        if (r.kind == 2) chk("timeout_latency", cyc - cs_cyc, TIMEOUT_CYC + 1);
      end
    end
  end
  task automatic launch(logic [31:0] f, logic [31:0] l, logic [7:0] t, bit nr);
    res_t r;
    @(negedge clk);
    noresp = nr;
    r = '{default: 0};
    r.hdr = {$urandom, $urandom, $urandom};
    r.tgt = t;
    if (f > l) begin
      r.exh = 1;
      r.kind = 1;
    end else for (longint n = f; n <= l; n++) begin
      exp_n.push_back(32'(n));
      r.att++;
      if (nr) begin
        r.tmo = 1;
        r.kind = 2;
        break;
      end
      if (hash_fn(32'(n))[23:16] < t) begin
        r.hits++;
        r.found = 1;
        r.hn = 32'(n);
        r.hh = hash_fn(32'(n));
        break;
      end
      if (n == l) r.exh = 1;
    end
    header_in = r.hdr;
    nonce_first = f;
    nonce_last = l;
    target_in = t;
    start = 1;
    r.scyc = cyc;
    exp_r.push_back(r);
    @(negedge clk);
    start = 0;
    header_in = {$urandom, $urandom, $urandom};
    nonce_first = $urandom;
    nonce_last = $urandom;
    target_in = 8'($urandom);
  endtask
  task automatic wait_done();
    int k;
    for (k = 0; k < 3000 && !done; k++) begin
      start = (k == 2) && busy;
      @(negedge clk);
    end
    start = 0;
    if (k == 3000) fail_now("done never arrived");
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_outs", {core_start, done, found, exhausted, timeout_err, attempts, hits}, 0);
    chk("reset_nonce", core_nonce, 0);
    reset = 0;
    hmode = 1;
    special = 32'h3C87EDFF;
    launch(32'h3C87EDFD, 32'h3C87EE06, 8'h20, 0);
    wait_done();
    hmode = 0;
    launch(0, 3, 8'h00, 0);
    wait_done();
    launch(32'hFFFFFFFE, 32'hFFFFFFFF, 8'h00, 0);
    wait_done();
    launch(5, 4, 8'hFF, 0);
    wait_done();
    launch(32'h40, 32'h50, 8'hFF, 1);
    wait_done();
    launch(32'h100, 32'h1FF, 8'h00, 1);
    for (int k = 0; k < 20 && !core_start; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_outs", {core_start, done, found, exhausted, timeout_err, attempts, hits}, 0);
    chk("abort_regs", {core_nonce, core_target, hit_nonce, hit_hash}, 0);
    chk("abort_header", core_header, 0);
    exp_n.delete();
    exp_r.delete();
    reset = 0;
    launch(32'h200, 32'h203, 8'h00, 0);
    wait_done();
    for (int i = 0; i < 30; i++) begin
      logic [31:0] f, l;
      salt = 8'($urandom);
      f = $urandom;
      l = f + 32'($urandom_range(0, 7));
      if (l < f) l = 32'hFFFFFFFF;
      if ($urandom_range(0, 5) == 0 && f != 0) l = f - 1;
      launch(f, l, 8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
      wait_done();
    end
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_n.size() + exp_r.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
